satswarm_top: RTL and testbench



---
 rtl/satswarm_top.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_satswarm_top.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/satswarm_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : satswarm_top                                                    |
// | Desc   : SatSwarm SAT accelerator: CNF broadcast to a grid of DPLL cores.|
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+

module satswarm_trail #(
  parameter int DEPTH = 42,
  parameter int HW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          push_value,
  input  logic          push_fixed,
  input  logic          pop,
  input  logic          flip,
  input  logic [HW-1:0] rd_var,
  output logic          rd_assigned,
  output logic          rd_value,
  output logic          top_fixed,
  output logic          top_flipped,
  output logic [31:0]   top_variable,
  output logic [HW-1:0] height
);
  typedef struct packed {
    logic [31:0] variable;
    logic        value;
    logic        fixed;
    logic        flipped;
  } trail_entry_t;

  trail_entry_t  trail [DEPTH];
  logic [HW-1:0] trail_height_q;
  logic [HW-1:0] w_top;
  logic [HW-1:0] w_rd_idx;
  logic          w_nonempty;

  // Entry i always holds variable i+1, so assignment lookup is a direct index.
  assign w_top        = trail_height_q - 1'b1;
  assign w_rd_idx     = rd_var - 1'b1;
  assign w_nonempty   = (trail_height_q != '0);
  assign height       = trail_height_q;
  assign rd_assigned  = (rd_var != '0) && (rd_var <= trail_height_q);
  assign rd_value     = rd_assigned ? trail[w_rd_idx].value : 1'b0;
  assign top_fixed    = w_nonempty ? trail[w_top].fixed : 1'b0;
  assign top_flipped  = w_nonempty ? trail[w_top].flipped : 1'b0;
  assign top_variable = w_nonempty ? trail[w_top].variable : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trail_height_q <= '0;
      for (int i = 0; i < DEPTH; i++) trail[i] <= '0;
    end else if (push) begin
      trail[trail_height_q] <= '{variable: 32'(trail_height_q) + 32'd1,
                                 value: push_value, fixed: push_fixed, flipped: 1'b0};
      trail_height_q        <= trail_height_q + 1'b1;
    end else if (pop) begin
      trail[w_top]   <= '0;
      trail_height_q <= w_top;
    end else if (flip) begin
      trail[w_top].value   <= 1'b1;
      trail[w_top].flipped <= 1'b1;
    end
  end
endmodule

module satswarm_core #(
  parameter int CORE_ID     = 0,
  parameter int PREFIX_BITS = 2,
  parameter int MAX_VARS    = 42,
  parameter int MAX_LITS    = 416,
  parameter int VW          = 6,
  parameter int LW          = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          wr_en,
  input  logic [LW-1:0] wr_addr,
  input  logic [VW+1:0] wr_data,
  input  logic [LW-1:0] lit_count,
  input  logic [VW-1:0] max_var,
  output logic          is_sat,
  output logic          is_unsat
);
  typedef enum logic [2:0] {
    S_IDLE, S_PREFIX, S_SCAN, S_DECIDE, S_BACKTRACK, S_SAT, S_UNSAT
  } state_t;

  localparam logic [31:0]   c_core_id    = 32'(CORE_ID);
  localparam logic [VW-1:0] c_prefix_len = VW'(PREFIX_BITS);

  state_t        r_state, w_state_n;
  logic [VW+1:0] r_lit_mem [MAX_LITS];
  logic [LW-1:0] r_idx, w_idx_n;
  logic          r_clause_ok, w_ok_n;
  logic          w_push, w_push_value, w_push_fixed, w_pop, w_flip;
  logic [VW+1:0] w_entry;
  logic          w_lit_sign, w_lit_end, w_lit_nonfalse;
  logic [VW-1:0] w_lit_var, w_height, w_plen;
  logic          w_rd_assigned, w_rd_value, w_top_fixed, w_top_flipped;
  logic          w_prefix_value;
  logic [31:0]   w_top_variable;
  logic          w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LITS; i++) r_lit_mem[i] <= '0;
    end else if (wr_en) begin
      r_lit_mem[wr_addr] <= wr_data;
    end
  end

  // Store entry layout: {negated, variable, clause_end}.
  assign w_entry        = r_lit_mem[r_idx];
  assign w_lit_sign     = w_entry[VW+1];
  assign w_lit_var      = w_entry[VW:1];
  assign w_lit_end      = w_entry[0];
  assign w_lit_nonfalse = !w_rd_assigned || (w_rd_value ^ w_lit_sign);
  assign w_plen         = (c_prefix_len < max_var) ? c_prefix_len : max_var;
  assign w_prefix_value = |((c_core_id >> w_height) & 32'd1);
  assign is_sat         = (r_state == S_SAT);
  assign is_unsat       = (r_state == S_UNSAT);
  assign w_unused       = ^w_top_variable;

  satswarm_trail #(.DEPTH(MAX_VARS), .HW(VW)) u_trail (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (w_push),
    .push_value   (w_push_value),
    .push_fixed   (w_push_fixed),
    .pop          (w_pop),
    .flip         (w_flip),
    .rd_var       (w_lit_var),
    .rd_assigned  (w_rd_assigned),
    .rd_value     (w_rd_value),
    .top_fixed    (w_top_fixed),
    .top_flipped  (w_top_flipped),
    .top_variable (w_top_variable),
    .height       (w_height)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_clause_ok <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_clause_ok <= w_ok_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_ok_n       = r_clause_ok;
    w_push       = 1'b0;
    w_push_value = 1'b0;
    w_push_fixed = 1'b0;
    w_pop        = 1'b0;
    w_flip       = 1'b0;
    // A SAT elsewhere in the grid freezes this core wherever it is.
    if (!halt) begin
      case (r_state)
        S_IDLE: if (start) w_state_n = S_PREFIX;
        S_PREFIX: begin
          if (w_height < w_plen) begin
            w_push       = 1'b1;
            w_push_value = w_prefix_value;
            w_push_fixed = 1'b1;
            if (w_height + 1'b1 >= w_plen) w_state_n = S_SCAN;
          end else begin
            w_state_n = S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_idx == lit_count) begin
            w_idx_n   = '0;
            w_ok_n    = 1'b0;
            w_state_n = (w_height == max_var) ? S_SAT : S_DECIDE;
          end else if (w_lit_end) begin
            if (!(r_clause_ok || w_lit_nonfalse)) begin
              w_idx_n   = '0;
              w_ok_n    = 1'b0;
              w_state_n = S_BACKTRACK;
            end else begin
              w_idx_n = r_idx + 1'b1;
              w_ok_n  = 1'b0;
            end
          end else begin
            w_idx_n = r_idx + 1'b1;
            w_ok_n  = r_clause_ok | w_lit_nonfalse;
          end
        end
        S_DECIDE: begin
          w_push    = 1'b1;
          w_state_n = S_SCAN;
        end
        S_BACKTRACK: begin
          if (w_height == '0 || w_top_fixed) begin
            w_state_n = S_UNSAT;
          end else if (w_top_flipped) begin
            w_pop = 1'b1;
          end else begin
            w_flip    = 1'b1;
            w_state_n = S_SCAN;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module satswarm_top #(
  parameter int GRID_X               = 2,
  parameter int GRID_Y               = 2,
  parameter int MAX_VARS_PER_CORE    = 42,
  parameter int MAX_CLAUSES_PER_CORE = 104,
  parameter int MAX_LITS             = 416
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_load_valid,
  input  logic [31:0] host_load_literal,
  input  logic        host_load_clause_end,
  output logic        host_load_ready,
  input  logic        host_start,
  output logic        host_done,
  output logic        host_sat,
  output logic        host_unsat,
  output logic        ddr_read_req,
  output logic [31:0] ddr_read_addr,
  output logic [7:0]  ddr_read_len,
  input  logic        ddr_read_grant,
  input  logic [31:0] ddr_read_data,
  input  logic        ddr_read_valid,
  output logic        ddr_write_req,
  output logic [31:0] ddr_write_addr,
  output logic [31:0] ddr_write_data,
  input  logic        ddr_write_grant
);
  localparam int c_ncores = GRID_X * GRID_Y;
  localparam int c_pbits  = $clog2(c_ncores);
  localparam int c_vw     = $clog2(MAX_VARS_PER_CORE + 1);
  localparam int c_lw     = $clog2(MAX_LITS + 1);
  localparam int c_cw     = $clog2(MAX_CLAUSES_PER_CORE + 1);

  logic [c_lw-1:0]     r_lit_count;
  logic [c_cw-1:0]     r_clause_count;
  logic [c_vw-1:0]     r_max_var;
  logic [31:0]         w_abs;
  logic                w_legal, w_wr, w_start;
  logic [c_vw+1:0]     w_wr_data;
  logic [c_ncores-1:0] w_sat_vec, w_unsat_vec;
  logic                w_any_sat, w_all_unsat;
  logic                w_unused_ddr;

  assign ddr_read_req   = 1'b0;
  assign ddr_read_addr  = 32'd0;
  assign ddr_read_len   = 8'd0;
  assign ddr_write_req  = 1'b0;
  assign ddr_write_addr = 32'd0;
  assign ddr_write_data = 32'd0;
  assign w_unused_ddr   = ^{ddr_read_grant, ddr_read_data, ddr_read_valid, ddr_write_grant};

  // Over-capacity or out-of-range literals are dropped rather than wrapped.
  assign w_abs     = host_load_literal[31] ? (32'd0 - host_load_literal) : host_load_literal;
  assign w_legal   = (w_abs != 32'd0) && (w_abs <= 32'(MAX_VARS_PER_CORE)) &&
                     (r_lit_count < c_lw'(MAX_LITS)) &&
                     (r_clause_count < c_cw'(MAX_CLAUSES_PER_CORE));
  assign w_wr      = host_load_valid && host_load_ready && w_legal;
  assign w_wr_data = {host_load_literal[31], w_abs[c_vw-1:0], host_load_clause_end};
  assign w_start   = host_start && host_load_ready;

  assign w_any_sat   = |w_sat_vec;
  assign w_all_unsat = &w_unsat_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_load_ready <= 1'b1;
      r_lit_count     <= '0;
      r_clause_count  <= '0;
      r_max_var       <= '0;
      host_done       <= 1'b0;
      host_sat        <= 1'b0;
      host_unsat      <= 1'b0;
    end else begin
      if (w_start) host_load_ready <= 1'b0;
      if (w_wr) begin
        r_lit_count <= r_lit_count + 1'b1;
        if (host_load_clause_end) r_clause_count <= r_clause_count + 1'b1;
        if (w_abs[c_vw-1:0] > r_max_var) r_max_var <= w_abs[c_vw-1:0];
      end
      host_sat   <= host_sat | w_any_sat;
      host_unsat <= host_unsat | (w_all_unsat & ~w_any_sat & ~host_sat);
      host_done  <= host_done | w_any_sat | w_all_unsat;
    end
  end

  for (genvar y = 0; y < GRID_Y; y++) begin : cols
    for (genvar x = 0; x < GRID_X; x++) begin : rows
      satswarm_core #(
        .CORE_ID     (y * GRID_X + x),
        .PREFIX_BITS (c_pbits),
        .MAX_VARS    (MAX_VARS_PER_CORE),
        .MAX_LITS    (MAX_LITS),
        .VW          (c_vw),
        .LW          (c_lw)
      ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start),
        .halt      (w_any_sat),
        .wr_en     (w_wr),
        .wr_addr   (r_lit_count),
        .wr_data   (w_wr_data),
        .lit_count (r_lit_count),
        .max_var   (r_max_var),
        .is_sat    (w_sat_vec[y*GRID_X+x]),
        .is_unsat  (w_unsat_vec[y*GRID_X+x])
      );
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_satswarm_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_satswarm_top                                                 |
// | Desc   : Directed self-checking bench for the SatSwarm top.              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+

module tb_satswarm_top;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_load_valid, host_load_clause_end, host_start;
  logic [31:0] host_load_literal;
  logic        host_load_ready, host_done, host_sat, host_unsat;
  logic        ddr_read_req, ddr_write_req;
  logic [31:0] ddr_read_addr, ddr_write_addr, ddr_write_data;
  logic [7:0]  ddr_read_len;

  int n_vec = 0;
  int n_err = 0;
  int win;
  int cyc;
  bit mdl [0:42];
  int tc1[$], tc2[$], sat5[$], unsat5[$], none[$];

  always #5 clk = ~clk;

  satswarm_top dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .host_load_valid      (host_load_valid),
    .host_load_literal    (host_load_literal),
    .host_load_clause_end (host_load_clause_end),
    .host_load_ready      (host_load_ready),
    .host_start           (host_start),
    .host_done            (host_done),
    .host_sat             (host_sat),
    .host_unsat           (host_unsat),
    .ddr_read_req         (ddr_read_req),
    .ddr_read_addr        (ddr_read_addr),
    .ddr_read_len         (ddr_read_len),
    .ddr_read_grant       (1'b0),
    .ddr_read_data        (32'd0),
    .ddr_read_valid       (1'b0),
    .ddr_write_req        (ddr_write_req),
    .ddr_write_addr       (ddr_write_addr),
    .ddr_write_data       (ddr_write_data),
    .ddr_write_grant      (1'b0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // DIMACS-style list: 0 terminates each clause.
  task automatic load_cnf(input int q[$]);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] != 0) begin
        @(negedge clk);
        host_load_valid      = 1'b1;
        host_load_literal    = q[i];
        host_load_clause_end = (i + 1 < q.size()) && (q[i+1] == 0);
      end
    end
    @(negedge clk);
    host_load_valid      = 1'b0;
    host_load_clause_end = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!host_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_in_budget", {31'd0, host_done}, 32'd1);
  endtask

  task automatic grab_model();
    win = -1;
    for (int i = 0; i <= 42; i++) mdl[i] = 1'b0;
    if (dut.cols[0].rows[0].u_core.is_sat) begin
      win = 0;
      for (int i = 0; i < 42; i++) mdl[i+1] = dut.cols[0].rows[0].u_core.u_trail.trail[i].value;
    end else if (dut.cols[0].rows[1].u_core.is_sat) begin
      win = 1;
      for (int i = 0; i < 42; i++) mdl[i+1] = dut.cols[0].rows[1].u_core.u_trail.trail[i].value;
    end else if (dut.cols[1].rows[0].u_core.is_sat) begin
      win = 2;
      for (int i = 0; i < 42; i++) mdl[i+1] = dut.cols[1].rows[0].u_core.u_trail.trail[i].value;
    end else if (dut.cols[1].rows[1].u_core.is_sat) begin
      win = 3;
      for (int i = 0; i < 42; i++) mdl[i+1] = dut.cols[1].rows[1].u_core.u_trail.trail[i].value;
    end
  endtask

  function automatic bit model_ok(input int q[$]);
    bit hit = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == 0) begin
        if (!hit) return 1'b0;
        hit = 1'b0;
      end else if (q[i] > 0) begin
        hit |= mdl[q[i]];
      end else begin
        hit |= !mdl[-q[i]];
      end
    end
    return 1'b1;
  endfunction

  task automatic check_model(input string tag, input int q[$]);
    grab_model();
    check({tag, "_winner_found"}, {31'd0, win >= 0}, 32'd1);
    check({tag, "_model"}, {31'd0, model_ok(q)}, 32'd1);
  endtask

  initial begin
    tc1    = '{1, 2, 0, -1, 2, 0, 1, -2, 0};
    tc2    = '{1, 0, -1, 0};
    sat5   = '{1, 2, -3, 0, -1, -2, 4, 0, 2, 3, -5, 0, -3, -4, 5, 0, 1, -4, -5, 0,
               -1, 3, 4, 0, 2, -3, 5, 0, -2, 4, -5, 0, 1, 3, -4, 0, -1, -5, -2, 0};
    unsat5 = '{1, 2, 3, 0, 1, 2, -3, 0, 1, -2, 3, 0, 1, -2, -3, 0, -1, 2, 3, 0,
               -1, 2, -3, 0, -1, -2, 3, 0, -1, -2, -3, 0, 4, 5, 0, -4, -5, 0};
    none   = {};
    host_load_valid = 1'b0; host_load_literal = 32'd0; host_load_clause_end = 1'b0;
    host_start = 1'b0;
    do_reset();

    check("rst_ready", {31'd0, host_load_ready}, 32'd1);
    check("rst_flags", {29'd0, host_done, host_sat, host_unsat}, 32'd0);
    check("ddr_tied", {31'd0, |{ddr_read_req, ddr_write_req, ddr_read_len,
                                 ddr_read_addr, ddr_write_addr, ddr_write_data}}, 32'd0);

    // 3-clause SAT: only var1=1,var2=1 works, owned by core 3.
    load_cnf(tc1);
    repeat (100) @(negedge clk);
    check("idle_done", {31'd0, host_done}, 32'd0);
    check("idle_ready", {31'd0, host_load_ready}, 32'd1);
    pulse_start();
    check("ready_drop", {31'd0, host_load_ready}, 32'd0);
    wait_done(cyc);
    check("tc1_flags", {29'd0, host_done, host_sat, host_unsat}, 32'b110);
    check("tc1_core3", {31'd0, dut.cols[1].rows[1].u_core.is_sat}, 32'd1);
    check("tc1_var1", {31'd0, dut.cols[1].rows[1].u_core.u_trail.trail[0].value}, 32'd1);
    check("tc1_var2", {31'd0, dut.cols[1].rows[1].u_core.u_trail.trail[1].value}, 32'd1);
    check("tc1_varidx", dut.cols[1].rows[1].u_core.u_trail.trail[1].variable, 32'd2);
    check_model("tc1", tc1);

    // (1)(-1): every core runs out of assignments.
    do_reset();
    load_cnf(tc2);
    pulse_start();
    wait_done(cyc);
    check("tc2_flags", {29'd0, host_done, host_sat, host_unsat}, 32'b101);
    check("tc2_all_unsat", {28'd0, dut.cols[0].rows[0].u_core.is_unsat,
                            dut.cols[0].rows[1].u_core.is_unsat,
                            dut.cols[1].rows[0].u_core.is_unsat,
                            dut.cols[1].rows[1].u_core.is_unsat}, 32'hF);

    // 5-var SAT instance (satisfied by 1,-2,3,-4,5) with stray start pulses.
    do_reset();
    load_cnf(sat5);
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(cyc);
    check("sat5_flags", {29'd0, host_done, host_sat, host_unsat}, 32'b110);
    check_model("sat5", sat5);
    pulse_start();
    repeat (3) @(negedge clk);
    check("sat5_sticky", {28'd0, host_load_ready, host_done, host_sat, host_unsat}, 32'b0110);

    // 5-var UNSAT: all eight sign patterns over vars 1..3.
    do_reset();
    load_cnf(unsat5);
    pulse_start();
    wait_done(cyc);
    check("unsat5_flags", {29'd0, host_done, host_sat, host_unsat}, 32'b101);

    // Abort an UNSAT solve, then reload a SAT formula.
    do_reset();
    load_cnf(unsat5);
    pulse_start();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {28'd0, host_load_ready, host_done, host_sat, host_unsat}, 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_cnf(tc1);
    pulse_start();
    wait_done(cyc);
    check("reload_flags", {29'd0, host_done, host_sat, host_unsat}, 32'b110);
    check_model("reload", tc1);

    // Empty formula: SAT straight after prefix and a one-cycle scan.
    do_reset();
    load_cnf(none);
    pulse_start();
    wait_done(cyc);
    check("empty_fast", {31'd0, cyc <= 10}, 32'd1);
    check("empty_flags", {29'd0, host_done, host_sat, host_unsat}, 32'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
